// File: rtl/csr_access_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// csr_access_sequencer_pkg
//   Shared constants and types for the approximation-control CSR sequencer:
//   CSR indices of the three approximation-control registers, the CSR
//   instruction funct3 codes, the sequencer state encoding and the requester
//   identifiers used by the round-robin arbiter.
// ----------------------------------------------------------------------------
package csr_access_sequencer_pkg;

   // Approximation-control CSR indices (custom machine read/write space)
   localparam logic [11:0] CSR_ALU = 12'h7C0;
   localparam logic [11:0] CSR_MUL = 12'h7C1;
   localparam logic [11:0] CSR_DIV = 12'h7C2;

   // CSR instruction funct3 codes
   localparam logic [2:0] CSRRW  = 3'b001;
   localparam logic [2:0] CSRRS  = 3'b010;
   localparam logic [2:0] CSRRC  = 3'b011;
   localparam logic [2:0] CSRRWI = 3'b101;
   localparam logic [2:0] CSRRSI = 3'b110;
   localparam logic [2:0] CSRRCI = 3'b111;

   typedef enum logic [2:0] {
      CSRSEQ_IDLE  = 3'd0,
      CSRSEQ_READ  = 3'd1,
      CSRSEQ_HOLD  = 3'd2,
      CSRSEQ_WRITE = 3'd3,
      CSRSEQ_RESP  = 3'd4
   } csrseq_state_e;

   typedef enum logic {
      PORT_CORE = 1'b0,
      PORT_DBG  = 1'b1
   } port_e;

   // funct3 000 and 100 are not CSR accesses
   function automatic logic op_is_legal(input logic [2:0] op);
      return (op != 3'b000) && (op != 3'b100);
   endfunction

   // Swap forms always write, even when the value does not change
   function automatic logic op_is_swap(input logic [2:0] op);
      return (op == CSRRW) || (op == CSRRWI);
   endfunction

endpackage

// File: rtl/csr_access_sequencer_arbiter.sv
// ----------------------------------------------------------------------------
// csr_rr_arbiter
//   Two-way round-robin arbiter between the core and debug requesters.
//   Grants are combinational and only given while enable is high; on a tie
//   the port that was not granted last wins.
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   enable                 sequencer can accept a request this cycle
//   core_valid, dbg_valid  request valid from each port
//   core_grant, dbg_grant  one-hot grant (handshake) toward each port
// ----------------------------------------------------------------------------
module csr_rr_arbiter
   import csr_access_sequencer_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic core_valid,
   input  logic dbg_valid,
   output logic core_grant,
   output logic dbg_grant
);

   port_e last_grant;

   // Grant selection; a tie goes to the port not served last
   always_comb begin
      core_grant = 1'b0;
      dbg_grant  = 1'b0;
      if (enable) begin
         if (core_valid && dbg_valid) begin
            if (last_grant == PORT_DBG) begin
               core_grant = 1'b1;
            end else begin
               dbg_grant = 1'b1;
            end
         end else begin
            core_grant = core_valid;
            dbg_grant  = dbg_valid;
         end
      end
   end

   // Remember the last winner; reset to debug so the core wins the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= PORT_DBG;
      end else if (core_grant) begin
         last_grant <= PORT_CORE;
      end else if (dbg_grant) begin
         last_grant <= PORT_DBG;
      end
   end

endmodule

// File: rtl/csr_access_sequencer.sv
// ----------------------------------------------------------------------------
// csr_access_sequencer
//   Runs every read-modify-write on the approximation-control CSR file for
//   two requesters (core pipeline and debug/config). Each access reads the
//   old value, optionally writes the new one and returns a one-cycle
//   response. Writes to the multiplier/divider CSR wait while that unit has
//   an operation in flight so its mode never changes mid-operation.
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   core_req_* / dbg_req_*         valid/ready request: index, funct3, wdata
//   core_rsp_* / dbg_rsp_*         one-cycle response: old value, error flag
//   csr_read_enable/index/data     CSR file read port
//   csr_write_enable/index/data    CSR file write port
//   mul_busy, div_busy             unit has an operation in flight
// ----------------------------------------------------------------------------
module csr_access_sequencer
   import csr_access_sequencer_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IDX_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             core_req_valid,
   output logic             core_req_ready,
   input  logic [IDX_W-1:0] core_req_index,
   input  logic [2:0]       core_req_op,
   input  logic [XLEN-1:0]  core_req_wdata,
   output logic             core_rsp_valid,
   output logic [XLEN-1:0]  core_rsp_rdata,
   output logic             core_rsp_err,
   input  logic             dbg_req_valid,
   output logic             dbg_req_ready,
   input  logic [IDX_W-1:0] dbg_req_index,
   input  logic [2:0]       dbg_req_op,
   input  logic [XLEN-1:0]  dbg_req_wdata,
   output logic             dbg_rsp_valid,
   output logic [XLEN-1:0]  dbg_rsp_rdata,
   output logic             dbg_rsp_err,
   output logic             csr_read_enable,
   output logic [IDX_W-1:0] csr_read_index,
   input  logic [XLEN-1:0]  csr_read_data,
   output logic             csr_write_enable,
   output logic [IDX_W-1:0] csr_write_index,
   output logic [XLEN-1:0]  csr_write_data,
   input  logic             mul_busy,
   input  logic             div_busy
);

   csrseq_state_e    state_q;
   csrseq_state_e    state_d;
   logic [IDX_W-1:0] idx_q;
   logic [2:0]       op_q;
   logic [XLEN-1:0]  wdata_q;
   port_e            port_q;
   logic [XLEN-1:0]  old_q;
   logic [XLEN-1:0]  new_q;
   logic             err_q;

   logic             arb_enable;
   logic             core_grant;
   logic             dbg_grant;
   logic             accept;
   logic             idx_mapped;
   logic             read_err;
   logic             write_needed;
   logic             unit_busy;
   logic [XLEN-1:0]  read_new;

   // Ready is withheld during reset so every output is 0 while it is held
   assign arb_enable = (state_q == CSRSEQ_IDLE) && !reset;
   assign accept     = core_grant || dbg_grant;

   csr_rr_arbiter u_arbiter (
      .clk        (clk),
      .reset      (reset),
      .enable     (arb_enable),
      .core_valid (core_req_valid),
      .dbg_valid  (dbg_req_valid),
      .core_grant (core_grant),
      .dbg_grant  (dbg_grant)
   );

   // Decode of the latched request against the value being read
   always_comb begin
      idx_mapped = (idx_q == IDX_W'(CSR_ALU)) || (idx_q == IDX_W'(CSR_MUL)) ||
                   (idx_q == IDX_W'(CSR_DIV));
      read_err   = !idx_mapped || !op_is_legal(op_q);
      case (op_q)
         CSRRW, CSRRWI: read_new = wdata_q;
         CSRRS, CSRRSI: read_new = csr_read_data | wdata_q;
         default:       read_new = csr_read_data & ~wdata_q;
      endcase
      // Set/clear with an all-zero mask leaves the CSR untouched, so skip it
      write_needed = !read_err && (op_is_swap(op_q) || (wdata_q != '0));
      unit_busy    = ((idx_q == IDX_W'(CSR_MUL)) && mul_busy) ||
                     ((idx_q == IDX_W'(CSR_DIV)) && div_busy);
   end

   // Request latch on handshake and read capture; an unmapped index reads
   // as a floating bus, so the error path stores 0 instead
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         op_q    <= '0;
         wdata_q <= '0;
         port_q  <= PORT_CORE;
         old_q   <= '0;
         new_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            if (dbg_grant) begin
               idx_q   <= dbg_req_index;
               op_q    <= dbg_req_op;
               wdata_q <= dbg_req_wdata;
               port_q  <= PORT_DBG;
            end else begin
               idx_q   <= core_req_index;
               op_q    <= core_req_op;
               wdata_q <= core_req_wdata;
               port_q  <= PORT_CORE;
            end
         end
         if (state_q == CSRSEQ_READ) begin
            old_q <= read_err ? '0 : csr_read_data;
            new_q <= read_new;
            err_q <= read_err;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CSRSEQ_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; HOLD is only left once the unit's busy drops
   always_comb begin
      state_d = state_q;
      case (state_q)
         CSRSEQ_IDLE: begin
            if (accept) begin
               state_d = CSRSEQ_READ;
            end
         end
         CSRSEQ_READ: begin
            if (!write_needed) begin
               state_d = CSRSEQ_RESP;
            end else if (unit_busy) begin
               state_d = CSRSEQ_HOLD;
            end else begin
               state_d = CSRSEQ_WRITE;
            end
         end
         CSRSEQ_HOLD: begin
            if (!unit_busy) begin
               state_d = CSRSEQ_WRITE;
            end
         end
         CSRSEQ_WRITE: state_d = CSRSEQ_RESP;
         CSRSEQ_RESP:  state_d = CSRSEQ_IDLE;
         default:      state_d = CSRSEQ_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      core_req_ready   = core_grant;
      dbg_req_ready    = dbg_grant;
      core_rsp_valid   = 1'b0;
      core_rsp_rdata   = '0;
      core_rsp_err     = 1'b0;
      dbg_rsp_valid    = 1'b0;
      dbg_rsp_rdata    = '0;
      dbg_rsp_err      = 1'b0;
      csr_read_enable  = 1'b0;
      csr_read_index   = '0;
      csr_write_enable = 1'b0;
      csr_write_index  = '0;
      csr_write_data   = '0;
      case (state_q)
         CSRSEQ_READ: begin
            csr_read_enable = 1'b1;
            csr_read_index  = idx_q;
         end
         CSRSEQ_WRITE: begin
            csr_write_enable = 1'b1;
            csr_write_index  = idx_q;
            csr_write_data   = new_q;
         end
         CSRSEQ_RESP: begin
            if (port_q == PORT_DBG) begin
               dbg_rsp_valid = 1'b1;
               dbg_rsp_rdata = old_q;
               dbg_rsp_err   = err_q;
            end else begin
               core_rsp_valid = 1'b1;
               core_rsp_rdata = old_q;
               core_rsp_err   = err_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// ----------------------------------------------------------------------------
// tb_csr_access_sequencer
//   Drives both requesters and the busy inputs, emulates the CSR file and
//   predicts every cycle of the sequencer's behaviour from a transaction
//   model: when each access is granted, and on which cycle its read, write
//   and response appear.
// ----------------------------------------------------------------------------
module tb_csr_access_sequencer;
   import csr_access_sequencer_pkg::*;

   localparam int NCYC = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req_valid, core_req_ready;
   logic [11:0] core_req_index;
   logic [2:0]  core_req_op;
   logic [31:0] core_req_wdata;
   logic        core_rsp_valid;
   logic [31:0] core_rsp_rdata;
   logic        core_rsp_err;
   logic        dbg_req_valid, dbg_req_ready;
   logic [11:0] dbg_req_index;
   logic [2:0]  dbg_req_op;
   logic [31:0] dbg_req_wdata;
   logic        dbg_rsp_valid;
   logic [31:0] dbg_rsp_rdata;
   logic        dbg_rsp_err;
   logic        csr_read_enable;
   logic [11:0] csr_read_index;
   logic [31:0] csr_read_data;
   logic        csr_write_enable;
   logic [11:0] csr_write_index;
   logic [31:0] csr_write_data;
   logic        mul_busy, div_busy;

   always #5 clk = ~clk;

   csr_access_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .core_req_valid   (core_req_valid),
      .core_req_ready   (core_req_ready),
      .core_req_index   (core_req_index),
      .core_req_op      (core_req_op),
      .core_req_wdata   (core_req_wdata),
      .core_rsp_valid   (core_rsp_valid),
      .core_rsp_rdata   (core_rsp_rdata),
      .core_rsp_err     (core_rsp_err),
      .dbg_req_valid    (dbg_req_valid),
      .dbg_req_ready    (dbg_req_ready),
      .dbg_req_index    (dbg_req_index),
      .dbg_req_op       (dbg_req_op),
      .dbg_req_wdata    (dbg_req_wdata),
      .dbg_rsp_valid    (dbg_rsp_valid),
      .dbg_rsp_rdata    (dbg_rsp_rdata),
      .dbg_rsp_err      (dbg_rsp_err),
      .csr_read_enable  (csr_read_enable),
      .csr_read_index   (csr_read_index),
      .csr_read_data    (csr_read_data),
      .csr_write_enable (csr_write_enable),
      .csr_write_index  (csr_write_index),
      .csr_write_data   (csr_write_data),
      .mul_busy         (mul_busy),
      .div_busy         (div_busy)
   );

   typedef struct {
      bit          pend;
      logic [11:0] idx;
      logic [2:0]  op;
      logic [31:0] wdata;
   } req_t;

   int          compared = 0;
   int          mismatched = 0;
   int          cyc;
   bit          rand_en;
   req_t        rq [2];
   bit          mul_b [NCYC];
   bit          div_b [NCYC];
   logic [31:0] model_regs [3];
   logic [31:0] env_regs [3] = '{32'h0, 32'h0, 32'h0};

   // Transaction model state
   int          free_cycle;
   int          last_grant;
   int          exp_port;
   int          exp_read_c, exp_write_c, exp_rsp_c;
   int          wr_slot;
   logic [11:0] exp_idx;
   logic [31:0] exp_wdata, exp_rdata;
   bit          exp_err;

   // CSR file stand-in; unmapped indices return junk as a floating bus would
   always_comb begin
      case (csr_read_index)
         CSR_ALU: csr_read_data = env_regs[0];
         CSR_MUL: csr_read_data = env_regs[1];
         CSR_DIV: csr_read_data = env_regs[2];
         default: csr_read_data = 32'hBAD0_BAD0 ^ {20'h0, csr_read_index};
      endcase
   end

   always @(negedge clk) begin
      if (csr_write_enable) begin
         case (csr_write_index)
            CSR_ALU: env_regs[0] <= csr_write_data;
            CSR_MUL: env_regs[1] <= csr_write_data;
            CSR_DIV: env_regs[2] <= csr_write_data;
            default: ;
         endcase
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", tag, cyc,
                  observed, expected);
      end
   endtask

   function automatic int slotOf(input logic [11:0] idx);
      if (idx == CSR_ALU) return 0;
      if (idx == CSR_MUL) return 1;
      if (idx == CSR_DIV) return 2;
      return -1;
   endfunction

   function automatic bit busyAt(input int slot, input int t);
      if (t >= NCYC) return 1'b0;
      if (slot == 1) return mul_b[t];
      if (slot == 2) return div_b[t];
      return 1'b0;
   endfunction

   function automatic req_t randomRequest();
      req_t r;
      int   pick;
      pick    = $urandom_range(0, 99);
      r.pend  = 1'b1;
      if (pick < 30)      r.idx = CSR_ALU;
      else if (pick < 55) r.idx = CSR_MUL;
      else if (pick < 80) r.idx = CSR_DIV;
      else                r.idx = 12'($urandom);
      r.op    = 3'($urandom);
      r.wdata = r.op[2] ? 32'($urandom_range(0, 31)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) r.wdata = '0;
      return r;
   endfunction

   task automatic clearExpect();
      exp_read_c  = -1;
      exp_write_c = -1;
      exp_rsp_c   = -1;
      wr_slot     = -1;
      exp_port    = -1;
   endtask

   task automatic issue(input int p, input logic [11:0] idx, input logic [2:0] op,
                        input logic [31:0] wd);
      rq[p].pend  = 1'b1;
      rq[p].idx   = idx;
      rq[p].op    = op;
      rq[p].wdata = wd;
   endtask

   task automatic applyStimulus();
      core_req_valid = rq[0].pend;
      core_req_index = rq[0].idx;
      core_req_op    = rq[0].op;
      core_req_wdata = rq[0].wdata;
      dbg_req_valid  = rq[1].pend;
      dbg_req_index  = rq[1].idx;
      dbg_req_op     = rq[1].op;
      dbg_req_wdata  = rq[1].wdata;
      mul_busy       = (cyc < NCYC) ? mul_b[cyc] : 1'b0;
      div_busy       = (cyc < NCYC) ? div_b[cyc] : 1'b0;
   endtask

   // Predict the whole access from its handshake cycle: read one cycle later,
   // then either straight to the response, or wait out the unit's busy
   // period before the single write cycle and the response after it
   task automatic scheduleAccess(input int g);
      int          s, t;
      bit          err, wr, swap;
      logic [31:0] oldv, newv, wd;
      logic [2:0]  op;
      s    = slotOf(rq[g].idx);
      op   = rq[g].op;
      wd   = rq[g].wdata;
      swap = (op == CSRRW) || (op == CSRRWI);
      err  = (s < 0) || (op == 3'b000) || (op == 3'b100);
      oldv = err ? 32'h0 : model_regs[s];
      if (swap)                             newv = wd;
      else if (op == CSRRS || op == CSRRSI) newv = oldv | wd;
      else                                  newv = oldv & ~wd;
      wr = !err && (swap || wd != 32'h0);
      last_grant = g;
      exp_port   = g;
      exp_idx    = rq[g].idx;
      exp_rdata  = oldv;
      exp_err    = err;
      exp_read_c = cyc + 1;
      if (!wr) begin
         exp_write_c = -1;
         wr_slot     = -1;
         exp_rsp_c   = cyc + 2;
      end else begin
         t = cyc + 1;
         if (busyAt(s, t)) begin
            t = cyc + 2;
            while (busyAt(s, t)) t++;
         end
         exp_write_c = t + 1;
         exp_rsp_c   = t + 2;
         wr_slot     = s;
         exp_wdata   = newv;
      end
      free_cycle = exp_rsp_c + 1;
   endtask

   task automatic compareCycle(input int g);
      checkOutput("core_ready", 32'(core_req_ready), 32'(g == 0));
      checkOutput("dbg_ready", 32'(dbg_req_ready), 32'(g == 1));
      checkOutput("rd_en", 32'(csr_read_enable), 32'(cyc == exp_read_c));
      if (cyc == exp_read_c) checkOutput("rd_idx", 32'(csr_read_index), 32'(exp_idx));
      checkOutput("wr_en", 32'(csr_write_enable), 32'(cyc == exp_write_c));
      if (cyc == exp_write_c) begin
         checkOutput("wr_idx", 32'(csr_write_index), 32'(exp_idx));
         checkOutput("wr_data", csr_write_data, exp_wdata);
      end
      checkOutput("core_rsp", 32'(core_rsp_valid), 32'(cyc == exp_rsp_c && exp_port == 0));
      checkOutput("dbg_rsp", 32'(dbg_rsp_valid), 32'(cyc == exp_rsp_c && exp_port == 1));
      if (cyc == exp_rsp_c && exp_port == 0) begin
         checkOutput("core_rdata", core_rsp_rdata, exp_rdata);
         checkOutput("core_err", 32'(core_rsp_err), 32'(exp_err));
      end
      if (cyc == exp_rsp_c && exp_port == 1) begin
         checkOutput("dbg_rdata", dbg_rsp_rdata, exp_rdata);
         checkOutput("dbg_err", 32'(dbg_rsp_err), 32'(exp_err));
      end
   endtask

   task automatic checkAllZero(input string pre);
      checkOutput({pre, "_core_ready"}, 32'(core_req_ready), 32'h0);
      checkOutput({pre, "_dbg_ready"}, 32'(dbg_req_ready), 32'h0);
      checkOutput({pre, "_rd_en"}, 32'(csr_read_enable), 32'h0);
      checkOutput({pre, "_rd_idx"}, 32'(csr_read_index), 32'h0);
      checkOutput({pre, "_wr_en"}, 32'(csr_write_enable), 32'h0);
      checkOutput({pre, "_wr_idx"}, 32'(csr_write_index), 32'h0);
      checkOutput({pre, "_wr_data"}, csr_write_data, 32'h0);
      checkOutput({pre, "_core_rsp"}, 32'(core_rsp_valid), 32'h0);
      checkOutput({pre, "_core_rdata"}, core_rsp_rdata, 32'h0);
      checkOutput({pre, "_dbg_rsp"}, 32'(dbg_rsp_valid), 32'h0);
      checkOutput({pre, "_dbg_rdata"}, dbg_rsp_rdata, 32'h0);
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) begin
         int g;
         @(posedge clk);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (rand_en && !rq[p].pend && $urandom_range(0, 99) < 40) rq[p] = randomRequest();
         end
         applyStimulus();
         g = -1;
         if (cyc >= free_cycle) begin
            if (rq[0].pend && rq[1].pend) g = (last_grant == 1) ? 0 : 1;
            else if (rq[0].pend)          g = 0;
            else if (rq[1].pend)          g = 1;
         end
         if (g >= 0) scheduleAccess(g);
         @(negedge clk);
         compareCycle(g);
         if (g >= 0) rq[g].pend = 1'b0;
         if (cyc == exp_write_c && wr_slot >= 0) model_regs[wr_slot] = exp_wdata;
         cyc++;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((rq[0].pend || rq[1].pend || cyc < free_cycle) && n < 400) begin
         runCycles(1);
         n++;
      end
      if (n >= 400) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain: still busy after %0d cycles, want idle", n);
      end
   endtask

   task automatic fillBusy(input int from, input int len);
      int mul_run = 0;
      int div_run = 0;
      for (int t = from; t < from + len && t < NCYC - 16; t++) begin
         if (mul_run > 0) begin
            mul_b[t] = 1'b1;
            mul_run--;
         end else if ($urandom_range(0, 99) < 10) begin
            mul_run = $urandom_range(1, 6);
         end
         if (div_run > 0) begin
            div_b[t] = 1'b1;
            div_run--;
         end else if ($urandom_range(0, 99) < 10) begin
            div_run = $urandom_range(1, 6);
         end
      end
   endtask

   initial begin
      rand_en    = 1'b0;
      cyc        = 0;
      free_cycle = 0;
      last_grant = 1;
      clearExpect();
      for (int i = 0; i < 3; i++) model_regs[i] = 32'h0;
      for (int p = 0; p < 2; p++) rq[p] = '{pend: 1'b0, idx: 12'h0, op: 3'h0, wdata: 32'h0};
      for (int t = 0; t < NCYC; t++) begin
         mul_b[t] = 1'b0;
         div_b[t] = 1'b0;
      end
      reset = 1'b1;
      applyStimulus();
      #2;
      checkAllZero("rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Swap after reset, then a zero-mask set (no write) and a clear-immediate
      issue(0, CSR_ALU, CSRRW, 32'h0000_00FF);
      runCycles(4);
      checkOutput("alu_after_rw", env_regs[0], 32'h0000_00FF);
      issue(0, CSR_ALU, CSRRS, 32'h0);
      runCycles(3);
      issue(0, CSR_ALU, CSRRCI, 32'h0000_000F);
      runCycles(4);
      checkOutput("alu_after_rci", env_regs[0], 32'h0000_00F0);

      // Simultaneous requests from both ports, back to back
      for (int i = 0; i < 3; i++) begin
         if (!rq[0].pend) issue(0, CSR_ALU, CSRRW, 32'h11 * (i + 1));
         if (!rq[1].pend) issue(1, CSR_ALU, CSRRW, 32'hA0 + i);
         runCycles(4);
      end
      drain();

      // Divider busy for five cycles from the read; multiplier busy is irrelevant
      for (int t = cyc; t < cyc + 12; t++) mul_b[t] = 1'b1;
      for (int t = cyc + 1; t <= cyc + 5; t++) div_b[t] = 1'b1;
      issue(0, CSR_DIV, CSRRW, 32'h3);
      runCycles(9);
      checkOutput("div_after_hold", env_regs[2], 32'h3);
      drain();

      // Unmapped index and illegal funct3
      issue(1, 12'h123, CSRRW, 32'hDEAD_BEEF);
      runCycles(3);
      issue(0, CSR_ALU, 3'b100, 32'h1);
      runCycles(3);
      drain();

      // Randomized traffic with random busy bursts
      fillBusy(cyc, 1600);
      rand_en = 1'b1;
      runCycles(1500);
      rand_en = 1'b0;
      drain();

      // Reset while a multiplier write sits in HOLD
      for (int t = cyc; t < cyc + 40; t++) mul_b[t] = 1'b1;
      issue(0, CSR_MUL, CSRRW, 32'h5A5A_0001);
      runCycles(4);
      issue(0, CSR_ALU, CSRRS, 32'h0000_0100);
      applyStimulus();
      #1 reset = 1'b1;
      #1;
      checkAllZero("midrst");
      @(posedge clk);
      #1;
      checkAllZero("midrst_held");
      core_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      clearExpect();
      free_cycle = 0;
      last_grant = 1;
      for (int t = cyc; t < cyc + 40; t++) mul_b[t] = 1'b0;
      checkOutput("mul_no_write", env_regs[1], model_regs[1]);
      drain();
      runCycles(2);

      for (int i = 0; i < 3; i++) checkOutput("final_csr", env_regs[i], model_regs[i]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
